sub_bytes_state: RTL and testbench

Sequential AES SubBytes stage for a full 128-bit state. It accepts one state over a valid/ready handshake and substitutes its 16 bytes through `LANES` instances of the existing combinational `SubBytes` byte S-box, `LANES` bytes per cycle. It holds the result until the downstream ShiftRows stage takes it. It sits between AddRoundKey and ShiftRows in the AES-CTR round datapath.

---
 rtl/aes_pkg.sv | 18 +
 rtl/SubBytes.sv | 34 +++
 rtl/sub_bytes_state.sv | 95 +++++++++
 tb/tb_sub_bytes_state.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, SubBytes FSM encoding and byte access.
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned NBYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sb_state_e;

  // Byte k of a state; byte 0 is the most significant (FIPS-197 order).
  function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s, input int unsigned k);
    return s[STATE_W-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/SubBytes.sv
// Combinational AES S-box for one byte: GF(2^8) inverse followed by the affine map.
module SubBytes (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  always_comb begin
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = byte_i;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    byte_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/sub_bytes_state.sv
// Sequential SubBytes over a 128-bit state, LANES bytes per cycle, in-place write-back.
module sub_bytes_state
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int unsigned N     = NBYTES / LANES;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_state: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] buf_q, buf_d;
  int unsigned        base;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

  // First byte handled this cycle; a single pass needs no counter.
  assign base = (N > 1) ? 32'(cnt_q) * LANES : 32'd0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = get_byte(buf_q, base + int'(l));
    SubBytes u_sbox (
      .byte_i(lane_in[l]),
      .byte_o(lane_out[l])
    );
  end

  // Next-state: capture in IDLE, substitute in place during BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          buf_d[STATE_W-1-8*(base+l) -: 8] = lane_out[l];
        end
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode straight from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_state = buf_q;
  end

endmodule

// File: tb/tb_sub_bytes_state.sv
module tb_sub_bytes_state;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  // Extra instances for LANES = 1, 2, 8, 16
  logic [3:0]   b_in_valid = '0;
  logic [3:0]   b_in_ready;
  logic [3:0]   b_out_valid;
  logic [3:0]   b_busy;
  logic [127:0] b_out_state [4];
  logic [127:0] b_in_state = '0;
  logic         b_out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sub_bytes_state #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  sub_bytes_state #(.LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid[0]), .in_ready(b_in_ready[0]),
    .in_state(b_in_state), .out_valid(b_out_valid[0]), .out_ready(b_out_ready),
    .out_state(b_out_state[0]), .busy(b_busy[0])
  );

  sub_bytes_state #(.LANES(2)) dut_l2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid[1]), .in_ready(b_in_ready[1]),
    .in_state(b_in_state), .out_valid(b_out_valid[1]), .out_ready(b_out_ready),
    .out_state(b_out_state[1]), .busy(b_busy[1])
  );

  sub_bytes_state #(.LANES(8)) dut_l8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid[2]), .in_ready(b_in_ready[2]),
    .in_state(b_in_state), .out_valid(b_out_valid[2]), .out_ready(b_out_ready),
    .out_state(b_out_state[2]), .busy(b_busy[2])
  );

  sub_bytes_state #(.LANES(16)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid[3]), .in_ready(b_in_ready[3]),
    .in_state(b_in_state), .out_valid(b_out_valid[3]), .out_ready(b_out_ready),
    .out_state(b_out_state[3]), .busy(b_busy[3])
  );

  // Cycles from the accepting edge until out_valid of the main DUT; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_state !== 128'h0) begin failures++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
    checks++; if (b_out_valid !== 4'b0000) begin failures++; $display("FAIL reset_lanes_out_valid got=%b exp=0000", b_out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int lat;
    out_ready = 1'b1;
    in_state  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fips_busy got=%b exp=1", busy); end
    wait_out(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL fips_latency got=%0d exp=4", lat); end
    checks++; if (out_state !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      failures++; $display("FAIL fips_out_state got=%h exp=d42711aee0bf98f1b8b45de51e415230", out_state);
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fips_no_bypass got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fips_out_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fips_idle_ready got=%b exp=1", in_ready); end
    checks++; if (out_state !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      failures++; $display("FAIL fips_out_state_kept got=%h exp=d42711aee0bf98f1b8b45de51e415230", out_state);
    end
  endtask

  task automatic test_byte_order();
    int exp_lat [4];
    int lat;
    exp_lat[0] = 16; exp_lat[1] = 8; exp_lat[2] = 2; exp_lat[3] = 1;
    b_in_state = 128'h000102030405060708090a0b0c0d0e0f;
    for (int k = 0; k < 4; k++) begin
      b_in_valid[k] = 1'b1;
      @(posedge clk); #1;
      b_in_valid[k] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (b_out_valid[k]) begin
          lat = c;
          break;
        end
      end
      checks++; if (lat !== exp_lat[k]) begin
        failures++; $display("FAIL byte_order_latency lane_cfg=%0d got=%0d exp=%0d", k, lat, exp_lat[k]);
      end
      checks++; if (b_out_state[k] !== 128'h637c777bf26b6fc53001672bfed7ab76) begin
        failures++; $display("FAIL byte_order_state lane_cfg=%0d got=%h exp=637c777bf26b6fc53001672bfed7ab76",
                             k, b_out_state[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_state;
    int bad_ready;
    int bad_valid;
    out_ready = 1'b0;
    in_state  = 128'h0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_state = {16{8'h53}};
    wait_out(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    bad_state = 0; bad_ready = 0; bad_valid = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_state !== {16{8'h63}}) bad_state++;
      if (in_ready !== 1'b0) bad_ready++;
      if (out_valid !== 1'b1) bad_valid++;
      @(posedge clk); #1;
    end
    checks++; if (bad_state != 0) begin failures++; $display("FAIL bp_state_stable bad_cycles=%0d exp=0", bad_state); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL bp_in_ready_low bad_cycles=%0d exp=0", bad_ready); end
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL bp_out_valid_held bad_cycles=%0d exp=0", bad_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_after_handshake got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_out_valid_after got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_second_accepted got=%b exp=1", busy); end
    wait_out(lat);
    checks++; if (out_state !== {16{8'hed}}) begin
      failures++; $display("FAIL bp_second_state got=%h exp=%h", out_state, {16{8'hed}});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    in_state  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_state !== 128'h0) begin failures++; $display("FAIL rstmid_out_state got=%h exp=0", out_state); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_output got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [3];
    logic [127:0] ex [3];
    int sidx;
    int ridx;
    int last;
    int accepting;
    st[0] = {16{8'h53}}; ex[0] = {16{8'hed}};
    st[1] = {16{8'h01}}; ex[1] = {16{8'h7c}};
    st[2] = {16{8'hff}}; ex[2] = {16{8'h16}};
    out_ready = 1'b1;
    sidx = 0; ridx = 0; last = 0;
    in_state = st[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && ridx < 3; cyc++) begin
      accepting = (in_ready === 1'b1 && in_valid === 1'b1) ? 1 : 0;
      @(posedge clk); #1;
      if (accepting != 0) begin
        sidx++;
        if (sidx < 3) in_state = st[sidx];
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_state !== ex[ridx]) begin
          failures++; $display("FAIL b2b_state idx=%0d got=%h exp=%h", ridx, out_state, ex[ridx]);
        end
        if (ridx > 0) begin
          checks++; if (cyc - last !== 6) begin
            failures++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", ridx, cyc - last);
          end
        end
        last = cyc;
        ridx++;
      end
    end
    in_valid = 1'b0;
    checks++; if (ridx !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", ridx); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_byte_order();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
